// File: rtl/addsub16_seq.sv
// addsub16_seq: nibble-serial two's-complement add/subtract.
// One 4-bit ripple-carry slice is reused over WIDTH/4 cycles. Operand B is
// inverted at load time for subtraction and the initial carry-in is set to 1.

// 4-bit ripple-carry adder slice (purely combinational).
module addsub16_seq_slice (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_c;

  // Ripple the carry through four full-adder cells.
  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < 4; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c[4];
  end
endmodule

module addsub16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_res;

  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;
  logic [3:0]       w_sum;
  logic             w_cout;
  logic             w_last;
  logic             w_load;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res_next;

  assign w_nib_a    = r_opA[{r_idx, 2'b00} +: 4];
  assign w_nib_b    = r_opB[{r_idx, 2'b00} +: 4];
  assign w_last     = (r_state == S_RUN) && (r_idx == LAST);
  // A new request is taken in IDLE, or at the edge that finishes the last
  // nibble so that back-to-back operations have no dead cycle.
  assign w_load     = start && ((r_state == S_IDLE) || w_last);
  // Result register shifts right: after NIBBLES shifts nibble 0 sits at the bottom.
  assign w_res_next = {w_sum, r_res[WIDTH-1:4]};
  // Signed overflow: operands (B already conditioned) agree in sign, result differs.
  assign w_ovf      = (r_opA[WIDTH-1] == r_opB[WIDTH-1]) && (w_sum[3] != r_opA[WIDTH-1]);

  addsub16_seq_slice u_slice (
    .i_a    (w_nib_a),
    .i_b    (w_nib_b),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Operand latching and result assembly; datapath needs no reset.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_opA <= A;
      r_opB <= sub ? ~B : B;
      r_res <= '0;
    end else if (r_state == S_RUN) begin
      r_res <= w_res_next;
    end
  end

  // Sequencer FSM: nibble index, carry chain, completion flags and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
        r_done <= 1'b1;
      end
      if (w_load) begin
        r_state <= S_RUN;
        r_busy  <= 1'b1;
        r_idx   <= '0;
        r_carry <= sub;
      end else if (w_last) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_idx   <= '0;
        r_carry <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_idx   <= r_idx + IDX_W'(1);
        r_carry <= w_cout;
      end
    end
  end

  assign busy  = r_busy;
  assign ready = ~r_busy;
  assign done  = r_done;
  assign Sum   = r_sum;
  assign Cout  = r_cout;
  assign Ovf   = r_ovf;
endmodule

// File: tb/tb_addsub16_seq.sv
// Scoreboard bench for addsub16_seq: the driver pushes expected results when
// its own acceptance model says a start is taken; a negedge monitor pops and
// compares whenever done is seen, and checks busy/ready and held outputs.
module tb_addsub16_seq;
  logic        clk = 1'b0;
  logic        rst, start, sub;
  logic [15:0] A, B;
  logic        ready, busy, done, Cout, Ovf;
  logic [15:0] Sum;

  addsub16_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
    .ready(ready), .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          n_edge  = 0;
  int          free_at = 0;
  int          n_acc   = 0;
  int          errors  = 0;
  int          checks  = 0;
  bit          mon_on  = 0;
  logic [15:0] last_s  = '0;
  logic        last_c  = 1'b0;
  logic        last_o  = 1'b0;

  always @(posedge clk) n_edge <= n_edge + 1;

  // Reference: unsigned sum gives Sum/Cout, true signed result gives Ovf.
  function automatic void ref_op(input logic [15:0] a, input logic [15:0] b, input logic sb,
                                 output logic [15:0] s, output logic c, output logic o);
    logic [16:0] full;
    int sa, sv, sr;
    full = {1'b0, a} + {1'b0, (sb ? ~b : b)} + {16'd0, sb};
    s  = full[15:0];
    c  = full[16];
    sa = int'($signed(a));
    sv = int'($signed(b));
    sr = sb ? (sa - sv) : (sa + sv);
    o  = (sr > 32767) || (sr < -32768);
  endfunction

  // Drive one cycle of inputs, then apply the model's view of that edge.
  task automatic cyc(input logic r, input logic s, input logic sb,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic dir, input logic [15:0] es, input logic ec, input logic eo);
    exp_t it;
    int   e;
    rst = r; start = s; sub = sb; A = a; B = b;
    @(posedge clk);
    #2;
    e = n_edge;
    if (r) begin
      q.delete();
      free_at = e;
      last_s = '0; last_c = 1'b0; last_o = 1'b0;
    end else if (s && (e >= free_at)) begin
      if (dir) begin
        it.s = es; it.c = ec; it.o = eo;
      end else begin
        ref_op(a, b, sb, it.s, it.c, it.o);
      end
      it.due  = e + 4;
      q.push_back(it);
      free_at = e + 4;
      n_acc++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic go(input logic [15:0] a, input logic [15:0] b, input logic sb,
                    input logic [15:0] es, input logic ec, input logic eo);
    cyc(1'b0, 1'b1, sb, a, b, 1'b1, es, ec, eo);
  endtask

  // Monitor: handshake state, done timing/contents, held outputs.
  always @(negedge clk) begin
    if (mon_on) begin
      int   k;
      logic exp_busy, exp_done;
      exp_t it;
      k = n_edge;
      exp_busy = (k < free_at);
      checks++;
      if (busy !== exp_busy || ready !== !exp_busy) begin
        errors++;
        $display("FAIL busy/ready at edge %0d: busy=%b ready=%b, required busy=%b", k, busy, ready, exp_busy);
      end
      exp_done = (q.size() > 0) && (q[0].due == k);
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL done at edge %0d: got %b, required %b", k, done, exp_done);
      end
      if (exp_done) begin
        it = q.pop_front();
        last_s = it.s; last_c = it.c; last_o = it.o;
      end
      checks++;
      if (Sum !== last_s || Cout !== last_c || Ovf !== last_o) begin
        errors++;
        $display("FAIL result at edge %0d: Sum=%h Cout=%b Ovf=%b, required Sum=%h Cout=%b Ovf=%b",
                 k, Sum, Cout, Ovf, last_s, last_c, last_o);
      end
    end
  end

  initial begin
    int iter;
    logic [15:0] ra, rb;
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 16'h1234, 16'h1234, 1'b0, '0, 1'b0, 1'b0);
    mon_on = 1;
    idle(2);

    // Basic add and boundary cases
    go(16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0); idle(5);
    go(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0); idle(5);
    go(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1); idle(5);
    go(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0); idle(5);
    go(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1); idle(5);

    // Start while busy is ignored; start in the done cycle is accepted
    go(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    idle(1);
    go(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    idle(2);
    go(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    idle(6);

    // Start at the completing edge: back-to-back with no gap
    go(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
    idle(3);
    go(16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);
    idle(6);

    // Abort mid-run with reset, then a clean operation
    go(16'h1234, 16'h1234, 1'b0, 16'h2468, 1'b0, 1'b0);
    idle(1);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    idle(6);
    go(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);
    idle(6);

    // Randomized sweep
    n_acc = 0;
    iter  = 0;
    while (n_acc < 1000 && iter < 20000) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 3))
        0: begin ra = 16'h7FFF; end
        1: begin rb = 16'h8000; end
        default: ;
      endcase
      if ($urandom_range(0, 399) == 0)
        cyc(1'b1, 1'($urandom), 1'b0, ra, rb, 1'b0, '0, 1'b0, 1'b0);
      else
        cyc(1'b0, 1'($urandom_range(0, 2) == 0), 1'($urandom), ra, rb, 1'b0, '0, 1'b0, 1'b0);
      iter++;
    end
    checks++;
    if (n_acc < 1000) begin
      errors++;
      $display("FAIL sweep budget: accepted %0d ops, required 1000", n_acc);
    end
    idle(8);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
